// File: rtl/norm_lut_scaler.sv
// LRN-style normalization stage: buffers a group of signed samples, turns their sum of
// squares into a scale-ROM address, then streams each sample times the looked-up scale.
module norm_lut_scaler #(
   parameter int DATA_WIDTH     = 16,
   parameter int GROUP_SIZE     = 4,
   parameter int LUT_ADDR_WIDTH = 6,
   parameter int LUT_DATA_WIDTH = 16,
   parameter int ADDR_SHIFT     = 8,
   parameter int FRAC_BITS      = 14
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic signed [DATA_WIDTH-1:0] in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [LUT_ADDR_WIDTH-1:0]    lut_address,
   output logic                         lut_enable,
   input  logic [LUT_DATA_WIDTH-1:0]    lut_data,
   output logic signed [DATA_WIDTH-1:0] out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [1:0]                   dbg_state
);

   // Handshakes: a transfer happens on a rising clk edge where valid and ready are both
   // high; valid never depends on ready, and out_data is stable while out_valid waits.

   localparam int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(GROUP_SIZE) + 1;
   localparam int IDX_WIDTH  = $clog2(GROUP_SIZE);
   localparam int SQ_WIDTH   = 2*DATA_WIDTH;
   localparam int PROD_WIDTH = DATA_WIDTH + LUT_DATA_WIDTH + 1;

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(GROUP_SIZE - 1);
   localparam logic signed [PROD_WIDTH-1:0] OUT_MAX =
      {{(PROD_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [PROD_WIDTH-1:0] OUT_MIN =
      {{(PROD_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_ACCUM  = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DRAIN  = 2'd3
   } state_t;

   state_t                       state_q, state_d;
   logic [IDX_WIDTH-1:0]         count_q, count_d;
   logic [IDX_WIDTH-1:0]         rd_idx_q, rd_idx_d;
   logic [ACC_WIDTH-1:0]         acc_q, acc_d;
   logic [LUT_DATA_WIDTH-1:0]    scale_q, scale_d;
   logic signed [DATA_WIDTH-1:0] smp_q [GROUP_SIZE];
   logic signed [DATA_WIDTH-1:0] smp_d [GROUP_SIZE];

   logic                         in_ready_q, in_ready_d;
   logic                         lut_enable_q, lut_enable_d;
   logic [LUT_ADDR_WIDTH-1:0]    lut_address_q, lut_address_d;
   logic                         out_valid_q, out_valid_d;
   logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;

   logic                         accept;
   logic                         out_fire;
   logic signed [SQ_WIDTH-1:0]   sq_s;
   logic [ACC_WIDTH-1:0]         acc_shift;
   logic [LUT_ADDR_WIDTH-1:0]    lookup_addr;
   logic signed [PROD_WIDTH-1:0] samp_ext;
   logic signed [PROD_WIDTH-1:0] scale_ext;
   logic signed [PROD_WIDTH-1:0] prod;
   logic signed [PROD_WIDTH-1:0] shifted;
   logic signed [DATA_WIDTH-1:0] sat_result;

   assign accept   = in_valid & in_ready_q;
   assign out_fire = out_valid_q & out_ready;
   assign sq_s     = in_data * in_data;

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      rd_idx_d = rd_idx_q;
      acc_d    = acc_q;
      scale_d  = scale_q;
      smp_d    = smp_q;
      case (state_q)
         ST_ACCUM: begin
            if (accept) begin
               smp_d[count_q] = in_data;
               acc_d = acc_q + ACC_WIDTH'($unsigned(sq_s));
               if (count_q == LAST_IDX) begin
                  count_d = '0;
                  state_d = ST_LOOKUP;
               end else begin
                  count_d = count_q + IDX_WIDTH'(1);
               end
            end
         end
         ST_LOOKUP: state_d = ST_WAIT;
         ST_WAIT: begin
            scale_d = lut_data;
            acc_d   = '0;
            state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (out_fire) begin
               if (rd_idx_q == LAST_IDX) begin
                  rd_idx_d = '0;
                  state_d  = ST_ACCUM;
               end else begin
                  rd_idx_d = rd_idx_q + IDX_WIDTH'(1);
               end
            end
         end
         default: state_d = ST_ACCUM;
      endcase
   end

   // Address comes from the next accumulator value so it already includes the last sample.
   always_comb begin
      acc_shift   = acc_d >> ADDR_SHIFT;
      lookup_addr = acc_shift[LUT_ADDR_WIDTH-1:0];
      if (|acc_shift[ACC_WIDTH-1:LUT_ADDR_WIDTH]) begin
         lookup_addr = '1;
      end
   end

   // Product is built from next-state index/scale so out_data is a plain register.
   always_comb begin
      samp_ext   = PROD_WIDTH'(smp_q[rd_idx_d]);
      scale_ext  = PROD_WIDTH'($signed({1'b0, scale_d}));
      prod       = samp_ext * scale_ext;
      shifted    = prod >>> FRAC_BITS;
      sat_result = shifted[DATA_WIDTH-1:0];
      if (shifted > OUT_MAX) begin
         sat_result = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else if (shifted < OUT_MIN) begin
         sat_result = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end
   end

   always_comb begin
      in_ready_d    = (state_d == ST_ACCUM);
      lut_enable_d  = (state_d == ST_LOOKUP);
      lut_address_d = lut_enable_d ? lookup_addr : lut_address_q;
      out_valid_d   = (state_d == ST_DRAIN);
      out_data_d    = out_valid_d ? sat_result : out_data_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_ACCUM;
         count_q       <= '0;
         rd_idx_q      <= '0;
         acc_q         <= '0;
         scale_q       <= '0;
         smp_q         <= '{default: '0};
         in_ready_q    <= 1'b0;
         lut_enable_q  <= 1'b0;
         lut_address_q <= '0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         rd_idx_q      <= rd_idx_d;
         acc_q         <= acc_d;
         scale_q       <= scale_d;
         smp_q         <= smp_d;
         in_ready_q    <= in_ready_d;
         lut_enable_q  <= lut_enable_d;
         lut_address_q <= lut_address_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign lut_enable  = lut_enable_q;
   assign lut_address = lut_address_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign dbg_state   = state_q;

endmodule
